// File: rtl/hub75_pkg.sv
// hub75_pkg: shared constants for the HUB75 scan controller.
//   - FSM state encodings (plain localparams so older tools and
//     netlists see stable 3-bit codes)
//   - register offsets within the 16-byte window
//   - CTRL field positions
package hub75_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE       = 3'd0;
  localparam state_t SHIFT_LO   = 3'd1;
  localparam state_t SHIFT_HI   = 3'd2;
  localparam state_t WAIT_BLANK = 3'd3;
  localparam state_t LATCH      = 3'd4;
  localparam state_t SETROW     = 3'd5;

  localparam logic [3:0] REG_DATA   = 4'h0;
  localparam logic [3:0] REG_CTRL   = 4'h4;
  localparam logic [3:0] REG_STATUS = 4'h8;
  localparam logic [3:0] REG_ONTIME = 4'hC;

  localparam int LATCH_BIT = 16;

endpackage

// File: rtl/hub75_fifo.sv
// hub75_fifo: synchronous colour-pair FIFO with a combinational read port.
//   clk, rst      core clock, async active-high reset (pointers/level only)
//   push, din     write one entry; allowed when full only if pop is also high
//   pop, dout     dout shows the head entry; pop advances it
//   full, empty   status flags
//   level         number of stored entries (0..DEPTH)
module hub75_fifo #(
  parameter int DEPTH = 64,
  parameter int W     = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  // Head is read before the edge, so a push into the slot being
  // popped on a full FIFO never disturbs the outgoing value.
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/hub75_scan_ctrl.sv
// hub75_scan_ctrl: bus-hub device driving a HUB75 LED panel.
//   clk, rst                     core clock, async active-high reset
//   addr, wdata, wmask, ren, wen bus request from the hub
//   rdata, ready                 registered response (1-cycle latency)
//   active                       combinational window decode
//   rgb, row, hub_clk, stb, oe   panel pins (oe=1 blanks the panel)
// Pixels are shifted from a FIFO; a latch request blanks (waits for the
// previous row's on-time to expire), pulses STB, switches row and starts
// a new on-time countdown that runs alongside further shifting.
module hub75_scan_ctrl #(
  parameter logic [31:0] BASE_ADDR  = 32'h0002_0000,
  parameter int          FIFO_DEPTH = 64,
  parameter int          CLK_DIV    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  input  logic        ren,
  input  logic        wen,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        active,
  output logic [5:0]  rgb,
  output logic [4:0]  row,
  output logic        hub_clk,
  output logic        stb,
  output logic        oe
);
  import hub75_pkg::*;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LOAD = DW'(CLK_DIV - 1);

  logic [31:0]   off_full;
  logic [3:0]    off;
  logic          data_wr, stall, acc, push, pop, full, empty;
  logic          ctrl_wr, ontime_wr, latch_req;
  logic [AW:0]   level;
  logic [5:0]    fifo_q;
  state_t        state, state_nxt;
  logic [DW-1:0] div_cnt;
  logic [15:0]   on_time, on_cnt, on_cnt_nxt;
  logic [4:0]    next_row;
  logic          latch_pending;
  logic [31:0]   rd_val;

  assign active   = (addr >= BASE_ADDR) && (addr < BASE_ADDR + 32'd16);
  assign off_full = addr - BASE_ADDR;
  assign off      = off_full[3:0];

  // A DATA push that would overflow is held off (no ready) until the
  // shifter frees a slot; the hub keeps the request stable meanwhile.
  // Gating on ~ready stops a held request being taken twice.
  assign data_wr   = active & wen & (off == REG_DATA) & wmask[0];
  assign stall     = data_wr & full & ~pop;
  assign acc       = active & (ren | wen) & ~ready & ~stall;
  assign push      = acc & data_wr;
  assign ctrl_wr   = acc & wen & (off == REG_CTRL);
  assign ontime_wr = acc & wen & (off == REG_ONTIME);
  assign latch_req = ctrl_wr & wmask[2] & wdata[LATCH_BIT];

  hub75_fifo #(.DEPTH(FIFO_DEPTH), .W(6)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .din(wdata[5:0]), .pop(pop),
    .dout(fifo_q), .full(full), .empty(empty), .level(level)
  );

  always_comb begin
    rd_val = '0;
    case (off)
      REG_CTRL:   rd_val = {15'b0, latch_pending, 11'b0, next_row};
      REG_STATUS: rd_val = {19'b0, latch_pending, state != IDLE, empty, full, 9'(level)};
      REG_ONTIME: rd_val = {16'b0, on_time};
      default:    rd_val = '0;
    endcase
  end

  // IDLE services the FIFO before a pending latch.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = SHIFT_LO;
        end else if (latch_pending) begin
          state_nxt = WAIT_BLANK;
        end
      end
      SHIFT_LO:   if (div_cnt == '0) state_nxt = SHIFT_HI;
      SHIFT_HI:   if (div_cnt == '0) state_nxt = IDLE;
      WAIT_BLANK: if (on_cnt == 16'd0) state_nxt = LATCH;
      LATCH:      if (div_cnt == '0) state_nxt = SETROW;
      SETROW:     state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  assign on_cnt_nxt = (state == SETROW)  ? on_time :
                      (on_cnt != 16'd0) ? on_cnt - 16'd1 : 16'd0;

  // Panel pins are registered from the next-state values so they
  // change cleanly on the edge that enters/leaves each state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      div_cnt       <= '0;
      rgb           <= '0;
      row           <= '0;
      hub_clk       <= 1'b0;
      stb           <= 1'b0;
      oe            <= 1'b1;
      on_cnt        <= '0;
      on_time       <= 16'd256;
      next_row      <= '0;
      latch_pending <= 1'b0;
      ready         <= 1'b0;
      rdata         <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)  div_cnt <= DIV_LOAD;
      else if (div_cnt != '0)  div_cnt <= div_cnt - 1'b1;
      hub_clk <= (state_nxt == SHIFT_HI);
      stb     <= (state_nxt == LATCH);
      if (pop) rgb <= fifo_q;
      if (state == SETROW) row <= next_row;
      on_cnt <= on_cnt_nxt;
      oe     <= (on_cnt_nxt == 16'd0);
      // A fresh request landing on the SETROW cycle must survive.
      if (latch_req)             latch_pending <= 1'b1;
      else if (state == SETROW)  latch_pending <= 1'b0;
      if (ctrl_wr && wmask[0]) next_row <= wdata[4:0];
      if (ontime_wr) begin
        if (wmask[0]) on_time[7:0]  <= wdata[7:0];
        if (wmask[1]) on_time[15:8] <= wdata[15:8];
      end
      ready <= acc;
      rdata <= (acc && ren) ? rd_val : 32'd0;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{off_full[31:4], wdata[31:17], wmask[3]};

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
module tb_hub75_scan_ctrl;
  localparam logic [31:0] BASE   = 32'h0002_0000;
  localparam int          CDIV   = 2;
  localparam logic [31:0] A_DATA = BASE;
  localparam logic [31:0] A_CTRL = BASE + 32'd4;
  localparam logic [31:0] A_STAT = BASE + 32'd8;
  localparam logic [31:0] A_ON   = BASE + 32'd12;

  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  wmask = '0;
  logic        ren = 1'b0, wen = 1'b0;
  logic [31:0] rdata;
  logic        ready, active, hub_clk, stb, oe;
  logic [5:0]  rgb;
  logic [4:0]  row;

  int total = 0, bad = 0;
  logic [5:0] q[$];

  always #5 clk = ~clk;

  hub75_scan_ctrl #(.BASE_ADDR(BASE), .FIFO_DEPTH(64), .CLK_DIV(CDIV)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wmask(wmask),
    .ren(ren), .wen(wen), .rdata(rdata), .ready(ready), .active(active),
    .rgb(rgb), .row(row), .hub_clk(hub_clk), .stb(stb), .oe(oe)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1);
  end

  // Bus transfer: call at a negedge, returns at the negedge where ready is seen.
  task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                     input logic wr, output logic [31:0] rd);
    int n = 0;
    logic got = 1'b0;
    addr = a; wdata = d; wmask = m; wen = wr; ren = ~wr; rd = '0;
    while (!got && n < 50) begin
      @(negedge clk); n++;
      if (ready) begin got = 1'b1; rd = rdata; end
    end
    wen = 1'b0; ren = 1'b0;
    total++;
    if (!got) begin
      bad++;
      $display("FAIL bus_timeout addr=%h: no ready, required ready within 50 cycles", a);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] dummy;
    bus(a, d, m, 1'b1, dummy);
  endtask

  task automatic wait_oe_low(input int budget);
    int n = 0;
    while (oe && n < budget) begin @(negedge clk); n++; end
    total++;
    if (oe) begin bad++; $display("FAIL oe_low_wait: oe=%0d after %0d cycles, required 0", oe, budget); end
  endtask

  task automatic test_reset;
    logic [31:0] v;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({rgb, row, hub_clk, stb, oe, ready, rdata} !== {6'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0}) begin
      bad++;
      $display("FAIL reset_outputs: rgb=%h row=%h hclk=%b stb=%b oe=%b rdy=%b rdata=%h, required 0,0,0,0,1,0,0",
               rgb, row, hub_clk, stb, oe, ready, rdata);
    end
    rst = 1'b0;
    @(negedge clk);
    bus(A_STAT, 0, 4'hF, 1'b0, v);
    total++;
    if (v !== 32'h400) begin bad++; $display("FAIL reset_status: got %h, required 00000400", v); end
    bus(A_ON, 0, 4'hF, 1'b0, v);
    total++;
    if (v !== 32'h100) begin bad++; $display("FAIL reset_ontime: got %h, required 00000100", v); end
  endtask

  task automatic test_decode;
    logic [31:0] v;
    logic seen = 1'b0;
    addr = BASE - 32'd4; ren = 1'b1; #1;
    total++;
    if (active !== 1'b0) begin bad++; $display("FAIL decode_below: active=%b, required 0", active); end
    addr = BASE + 32'd12; #1;
    total++;
    if (active !== 1'b1) begin bad++; $display("FAIL decode_top: active=%b, required 1", active); end
    addr = BASE + 32'd16; #1;
    total++;
    if (active !== 1'b0) begin bad++; $display("FAIL decode_above: active=%b, required 0", active); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ready !== 1'b0 || rdata !== 32'd0) seen = 1'b1;
    end
    ren = 1'b0;
    total++;
    if (seen) begin bad++; $display("FAIL decode_noresp: ready/rdata nonzero, required ready=0 rdata=0"); end
    wr(A_ON, 32'h0000_FFFF, 4'b0001);
    bus(A_ON, 0, 4'hF, 1'b0, v);
    total++;
    if (v !== 32'h1FF) begin bad++; $display("FAIL ontime_wmask: got %h, required 000001ff", v); end
  endtask

  task automatic test_pixel_shift;
    logic [31:0] v;
    logic [4:0] got_pat, exp_pat;
    int rises = 0;
    logic prev;
    wr(A_DATA, 32'h2A, 4'b0001);
    prev = hub_clk;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      got_pat[i] = hub_clk;
      exp_pat[i] = (i >= CDIV) && (i < 2 * CDIV);
      if (hub_clk && !prev) rises++;
      prev = hub_clk;
      if (i == 0) begin
        total++;
        if (rgb !== 6'h2A) begin bad++; $display("FAIL shift_rgb: got %h, required 2a", rgb); end
      end
    end
    total++;
    if (got_pat !== exp_pat) begin bad++; $display("FAIL shift_hclk_pattern: got %b, required %b", got_pat, exp_pat); end
    total++;
    if (rises != 1) begin bad++; $display("FAIL shift_rises: got %0d, required 1", rises); end
    bus(A_STAT, 0, 4'hF, 1'b0, v);
    total++;
    if (v !== 32'h400) begin bad++; $display("FAIL shift_idle_status: got %h, required 00000400", v); end
  endtask

  task automatic test_latch;
    int stb_cnt = 0, stb_rises = 0, fall_idx = -1, chg_idx = -1, low_cnt = 0, low_runs = 0;
    logic p_stb, p_oe;
    logic [4:0] p_row;
    wr(A_ON, 32'd10, 4'b0011);
    wr(A_CTRL, 32'h0001_0005, 4'b0101);
    p_stb = stb; p_oe = oe; p_row = row;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (stb) stb_cnt++;
      if (stb && !p_stb) stb_rises++;
      if (!stb && p_stb && fall_idx < 0) fall_idx = i;
      if (row != p_row && chg_idx < 0) chg_idx = i;
      if (!oe) low_cnt++;
      if (!oe && p_oe) low_runs++;
      p_stb = stb; p_oe = oe; p_row = row;
    end
    total++;
    if (stb_cnt != CDIV) begin bad++; $display("FAIL latch_stb_width: got %0d, required %0d", stb_cnt, CDIV); end
    total++;
    if (stb_rises != 1) begin bad++; $display("FAIL latch_stb_pulses: got %0d, required 1", stb_rises); end
    total++;
    if (!(fall_idx >= 0 && chg_idx >= fall_idx)) begin
      bad++; $display("FAIL latch_row_after_stb: row change at %0d, stb fall at %0d, required row change not before fall", chg_idx, fall_idx);
    end
    total++;
    if (row !== 5'd5) begin bad++; $display("FAIL latch_row: got %0d, required 5", row); end
    total++;
    if (low_cnt != 10 || low_runs != 1) begin
      bad++; $display("FAIL latch_on_time: oe low %0d cycles in %0d runs, required 10 in 1", low_cnt, low_runs);
    end
  endtask

  task automatic test_blank_wait;
    int viol_stb = 0, viol_row = 0, stb_rises = 0, low2 = 0;
    logic seen9 = 1'b0, p_stb, p_oe;
    logic [4:0] p_row;
    wr(A_ON, 32'd100, 4'b0011);
    wr(A_CTRL, 32'h0001_0001, 4'b0101);
    wait_oe_low(20);
    wr(A_CTRL, 32'h0001_0009, 4'b0101);
    wr(A_CTRL, 32'h0001_0002, 4'b0101);
    p_stb = stb; p_oe = oe; p_row = row;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (stb && !oe) viol_stb++;
      if (row != p_row && !p_oe) viol_row++;
      if (row == 5'd9) seen9 = 1'b1;
      if (stb && !p_stb) stb_rises++;
      if (row == 5'd2 && !oe) low2++;
      p_stb = stb; p_oe = oe; p_row = row;
    end
    total++;
    if (viol_stb != 0) begin bad++; $display("FAIL blank_stb_while_lit: %0d cycles, required 0", viol_stb); end
    total++;
    if (viol_row != 0) begin bad++; $display("FAIL blank_row_while_lit: %0d changes, required 0", viol_row); end
    total++;
    if (stb_rises != 1 || seen9) begin
      bad++; $display("FAIL blank_collapse: %0d stb pulses seen9=%b, required 1 pulse no row 9", stb_rises, seen9);
    end
    total++;
    if (row !== 5'd2 || low2 != 100) begin
      bad++; $display("FAIL blank_row2: row=%0d low=%0d, required row 2 low 100", row, low2);
    end
  endtask

  task automatic test_fifo_full;
    logic [31:0] v;
    logic [5:0] px, exp;
    logic early = 1'b0, got = 1'b0, prev;
    int n = 0;
    q.delete();
    wr(A_ON, 32'd600, 4'b0011);
    wr(A_CTRL, 32'h0001_0001, 4'b0101);
    wait_oe_low(20);
    wr(A_CTRL, 32'h0001_0003, 4'b0101);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 64; i++) begin
      px = 6'($urandom_range(0, 63));
      q.push_back(px);
      wr(A_DATA, {26'd0, px}, 4'b0001);
    end
    bus(A_STAT, 0, 4'hF, 1'b0, v);
    total++;
    if (v !== 32'h1A40) begin bad++; $display("FAIL full_status: got %h, required 00001a40", v); end
    px = 6'($urandom_range(0, 63));
    q.push_back(px);
    addr = A_DATA; wdata = {26'd0, px}; wmask = 4'b0001; wen = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ready) early = 1'b1;
    end
    while (!early && !got && n < 1000) begin
      @(negedge clk); n++;
      if (ready) got = 1'b1;
    end
    wen = 1'b0;
    total++;
    if (early) begin bad++; $display("FAIL full_stall: ready=1 while full, required 0"); end
    total++;
    if (!got && !early) begin bad++; $display("FAIL full_retry: no ready in 1000 cycles, required completion"); end
    prev = hub_clk;
    n = 0;
    while (q.size() > 0 && n < 2000) begin
      @(negedge clk); n++;
      if (hub_clk && !prev) begin
        exp = q.pop_front();
        total++;
        if (rgb !== exp) begin bad++; $display("FAIL full_order: rgb=%h, required %h", rgb, exp); end
      end
      prev = hub_clk;
    end
    total++;
    if (q.size() != 0) begin bad++; $display("FAIL full_drain: %0d pixels left, required 0", q.size()); end
  endtask

  task automatic test_back_to_back;
    int rises = 0;
    q.delete();
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          logic [5:0] px;
          px = 6'($urandom_range(0, 63));
          q.push_back(px);
          wr(A_DATA, {26'd0, px}, 4'b0001);
          repeat ($urandom_range(0, 6)) @(negedge clk);
        end
      end
      begin
        logic prev;
        logic [5:0] exp;
        prev = hub_clk;
        for (int j = 0; j < 400; j++) begin
          @(negedge clk);
          if (hub_clk && !prev) begin
            rises++;
            exp = (q.size() > 0) ? q.pop_front() : 6'h3F;
            total++;
            if (rgb !== exp) begin bad++; $display("FAIL b2b_pixel: rgb=%h, required %h", rgb, exp); end
          end
          prev = hub_clk;
        end
      end
    join
    total++;
    if (rises != 10 || q.size() != 0) begin
      bad++; $display("FAIL b2b_count: %0d rises %0d left, required 10 rises 0 left", rises, q.size());
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] v;
    int n = 0;
    wr(A_ON, 32'd50, 4'b0011);
    wr(A_CTRL, 32'h0001_0004, 4'b0101);
    while (!(row == 5'd4 && !oe) && n < 1000) begin @(negedge clk); n++; end
    total++;
    if (row !== 5'd4 || oe !== 1'b0) begin bad++; $display("FAIL mid_setup: row=%0d oe=%b, required row 4 oe 0", row, oe); end
    for (int i = 0; i < 3; i++) wr(A_DATA, 32'h15 + i, 4'b0001);
    wr(A_CTRL, 32'h0001_0007, 4'b0101);
    n = 0;
    while (!hub_clk && n < 50) begin @(negedge clk); n++; end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({oe, stb, hub_clk, row, rgb} !== {1'b1, 1'b0, 1'b0, 5'd0, 6'd0}) begin
      bad++; $display("FAIL mid_reset: oe=%b stb=%b hclk=%b row=%0d rgb=%h, required 1,0,0,0,00", oe, stb, hub_clk, row, rgb);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus(A_STAT, 0, 4'hF, 1'b0, v);
    total++;
    if (v !== 32'h400) begin bad++; $display("FAIL mid_status: got %h, required 00000400", v); end
    bus(A_CTRL, 0, 4'hF, 1'b0, v);
    total++;
    if (v !== 32'h0) begin bad++; $display("FAIL mid_ctrl: got %h, required 00000000", v); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_pixel_shift();
    test_latch();
    test_blank_wait();
    test_fifo_full();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
